// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per clock.
// Optional macro INV_SBOX_PIPE_EN registers lookup results before write-back (one extra cycle of latency).
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);
  localparam int B     = BYTES_PER_CYCLE;
  localparam int NSTEP = 16 / B;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSTEP - 1);

  if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_e;

  // Handshakes: a transfer occurs at a rising edge where valid and ready are both high;
  // out_valid and out_state stay unchanged from assertion until that transfer.
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  work_q;
  logic [127:0]  out_state_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;

  logic [7:0]    lk_out [B];
  logic          step_en;
  logic          wr_en;
  logic          wr_last;
  logic [CW-1:0] wr_cnt;
  logic [7:0]    wr_data [B];
  logic [127:0]  work_d;

  function automatic logic [7:0] byte_at(input logic [127:0] s, input int idx);
    return s[127 - 8*idx -: 8];
  endfunction

  always_comb begin
    for (int k = 0; k < B; k++) lk_out[k] = INV_SBOX[byte_at(work_q, int'(cnt_q) * B + k)];
  end

`ifdef INV_SBOX_PIPE_EN
  logic          pipe_vld_q;
  logic [CW-1:0] pipe_cnt_q;
  logic [7:0]    pipe_data_q [B];
  logic          drain_q;

  // Issue reads the original bytes; writes land one cycle later on disjoint byte slots.
  assign step_en = (state_q == LOAD) && !drain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= 1'b0;
      pipe_cnt_q <= '0;
      drain_q    <= 1'b0;
      for (int k = 0; k < B; k++) pipe_data_q[k] <= '0;
    end else begin
      pipe_vld_q <= step_en;
      pipe_cnt_q <= cnt_q;
      if (step_en) begin
        for (int k = 0; k < B; k++) pipe_data_q[k] <= lk_out[k];
      end
      if (step_en && cnt_q == LAST_CNT) drain_q <= 1'b1;
      else if (wr_last)                 drain_q <= 1'b0;
    end
  end

  always_comb begin
    wr_en   = pipe_vld_q;
    wr_last = drain_q;
    wr_cnt  = pipe_cnt_q;
    for (int k = 0; k < B; k++) wr_data[k] = pipe_data_q[k];
  end
`else
  assign step_en = (state_q == LOAD);

  always_comb begin
    wr_en   = (state_q == LOAD);
    wr_last = (state_q == LOAD) && (cnt_q == LAST_CNT);
    wr_cnt  = cnt_q;
    for (int k = 0; k < B; k++) wr_data[k] = lk_out[k];
  end
`endif

  always_comb begin
    work_d = work_q;
    for (int k = 0; k < B; k++) work_d[127 - 8*(int'(wr_cnt) * B + k) -: 8] = wr_data[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in_state;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (step_en) cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
          if (wr_en) work_q <= work_d;
          if (wr_last) begin
            out_state_q <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_state   = out_state_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: directed vectors, backpressure, mid-LOAD reset, round trip
// through a forward S-box, plus side instances for the other BYTES_PER_CYCLE values.
module tb_inv_sub_bytes_seq;
`ifdef INV_SBOX_PIPE_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int B   = 4;
  localparam int LAT = 16 / B + PX;

  localparam logic [127:0] V1  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] E1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A63 = {16{8'h63}};
  localparam logic [127:0] A16 = {16{8'h16}};
  localparam logic [127:0] AFF = {16{8'hff}};
  localparam logic [127:0] A52 = {16{8'h52}};
  localparam logic [127:0] A48 = {16{8'h48}};
  localparam logic [127:0] A7C = {16{8'h7c}};
  localparam logic [127:0] A01 = {16{8'h01}};
  localparam logic [127:0] A00 = {16{8'h00}};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   dbg_state;
  logic         alt_valid;
  logic [127:0] alt_state;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int alt_acc     = 0;
  int last_acc    = 0;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  bit           seen = 1'b0;
  logic [127:0] held;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(B)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Side instances for the other legal widths, each fed V1 once.
  for (genvar g = 0; g < 4; g++) begin : g_alt
    localparam int BB = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    logic         rdy, vld, bsy;
    logic [127:0] st;
    logic [1:0]   dst;
    int           got = 0;
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BB)) u_alt (
      .clk(clk), .rst_n(rst_n), .in_valid(alt_valid), .in_ready(rdy), .in_state(alt_state),
      .out_valid(vld), .out_ready(1'b1), .out_state(st), .busy(bsy), .dbg_state_o(dst)
    );
    always @(negedge clk) begin
      if (rst_n && vld) begin
        got++;
        chk($sformatf("alt_b%0d_state", BB), st, E1);
        chk($sformatf("alt_b%0d_latency", BB), 128'(cyc - alt_acc), 128'(16 / BB + PX));
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        if (!seen) begin
          chk("latency", 128'(cyc - acc_q[0]), 128'(LAT));
          seen = 1'b1;
          held = out_state;
        end else begin
          chk("hold_stable", out_state, held);
        end
        chk("in_ready_low_in_done", in_ready, 1'b0);
        if (out_ready) begin
          chk("out_state", out_state, exp_q.pop_front());
          void'(acc_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] e, input bit keep);
    int n = 0;
    in_valid = 1'b1;
    in_state = s;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
      last_acc = cyc + 1;
      step();
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [127:0] fwd(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = SBOX[s[127 - 8*j -: 8]];
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] orig;
    int a0, a1, a2, n;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
    alt_valid = 1'b0; alt_state = '0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    step();

    alt_state = V1; alt_valid = 1'b1; alt_acc = cyc + 1;
    step();
    alt_valid = 1'b0;

    send(A63, A00, 1'b0);
    chk("busy_in_load", busy, 1'b1);
    chk("in_ready_in_load", in_ready, 1'b0);
    chk("state_load", dbg_state, 2'd1);
    wait_idle();
    send(V1, E1, 1'b0);  wait_idle();
    send(A16, AFF, 1'b0); wait_idle();
    send(A00, A52, 1'b0); wait_idle();
    send(A7C, A01, 1'b0); wait_idle();

    // Backpressure: hold result, offer an input that must be ignored.
    out_ready = 1'b0;
    send(V1, E1, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_state_done", dbg_state, 2'd2);
    repeat (2) step();
    in_valid = 1'b1; in_state = A63;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    chk("handoff_out_valid", out_valid, 1'b0);
    chk("handoff_in_ready", in_ready, 1'b1);
    chk("handoff_retained", out_state, E1);
    repeat (3) step();

    // Reset just before the second substitution edge.
    send(V1, E1, 1'b0);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_state", out_state, '0);
    chk("midrst_state", dbg_state, 2'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    send(A52, A48, 1'b0); wait_idle();

    // Back-to-back with in_valid held high.
    send(V1, E1, 1'b1);   a0 = last_acc;
    send(A63, A00, 1'b1); a1 = last_acc;
    send(A16, AFF, 1'b0); a2 = last_acc;
    chk("spacing_0_1", 128'(a1 - a0), 128'(16 / B + 2 + PX));
    chk("spacing_1_2", 128'(a2 - a1), 128'(16 / B + 2 + PX));
    wait_idle();

    // Round trip: all 256 byte values, then random states.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) orig[127 - 8*j -: 8] = 8'(16 * i + j);
      send(fwd(orig), orig, 1'b1);
    end
    for (int i = 0; i < 24; i++) begin
      orig = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(fwd(orig), orig, (i != 23));
    end
    wait_idle();
    repeat (5) step();

    chk("alt_b1_count", 128'(g_alt[0].got), 128'(1));
    chk("alt_b2_count", 128'(g_alt[1].got), 128'(1));
    chk("alt_b8_count", 128'(g_alt[2].got), 128'(1));
    chk("alt_b16_count", 128'(g_alt[3].got), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
